uart_rx_oversampled: RTL

Oversampling UART receiver that consumes the serial test/UART line (uart_rxd_out) and recovers 8-bit characters. It runs on the system clock. Bit timing comes from an internal oversample counter (OVERSAMPLE clocks per bit), matching the by-16 baud divider used on the transmit side. Recovered bytes go to downstream logic through a one-entry valid/ready holding register. Framing and overrun errors are flagged, never silently dropped.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/bit_sync.sv | 23 ++
 rtl/uart_rx_oversampled.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error port.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_error,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int M     = OVERSAMPLE / 2;

  rx_state_t            state, state_next;
  logic                 rxd_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s_early, s_mid;
  logic                 vote;
  logic                 at_m1, at_mid, at_dec, at_end;
  logic                 commit, ferr_next;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 perr_next;
`endif

  bit_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxd_s)
  );

  assign at_m1  = (cnt == CNT_W'(M - 1));
  assign at_mid = (cnt == CNT_W'(M));
  assign at_dec = (cnt == CNT_W'(M + 1));
  assign at_end = (cnt == CNT_W'(OVERSAMPLE - 1));
  // Third vote sample is taken live in the decision cycle.
  assign vote   = majority3(s_early, s_mid, rxd_s);
  assign busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next  = 1'b0;
`endif
    case (state)
      IDLE:  if (!rxd_s) state_next = START;
      START: begin
        if (at_dec && vote) state_next = IDLE;
        else if (at_end)    state_next = DATA;
      end
      DATA: begin
        if (at_end && bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (at_end) state_next = STOP;
`endif
      // Stop decision ends the frame at mid-bit so the next start edge is caught.
      STOP: begin
        if (at_dec) begin
`ifdef UART_RX_PARITY_EN
          perr_next = vote & (^{shreg, par_bit});
`endif
          if (vote) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK:   if (rxd_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      s_early <= 1'b1;
      s_mid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      if (state == IDLE || at_end) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
      if (at_m1)  s_early <= rxd_s;
      if (at_mid) s_mid   <= rxd_s;
      if (state == START && at_end) bit_idx <= '0;
      if (state == DATA) begin
        if (at_dec) shreg <= {vote, shreg[DATA_BITS-1:1]};
        if (at_end) bit_idx <= bit_idx + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && at_dec) par_bit <= vote;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error <= ferr_next;
`ifdef UART_RX_PARITY_EN
      parity_error <= perr_next;
`endif
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
